// File: rtl/modport_table.sv
// Flop-based lookup table with INPUT_RATE write lanes and OUTPUT_RATE registered read lanes.
// Reads return pre-edge contents; on a same-index write collision the highest lane wins.
module modport_table #(
    parameter int TABLE_SIZE  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int INPUT_RATE  = 2,
    parameter int OUTPUT_RATE = 2,
    localparam int IW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INPUT_RATE-1:0]             wr_en,
    input  logic [INPUT_RATE*IW-1:0]          index_wr,
    input  logic [INPUT_RATE*DATA_WIDTH-1:0]  data_wr,
    input  logic                              rd_en,
    input  logic [OUTPUT_RATE*IW-1:0]         index_rd,
    output logic [OUTPUT_RATE*DATA_WIDTH-1:0] data_rd
);

    localparam bit POW2 = (TABLE_SIZE == (1 << IW));

    logic [DATA_WIDTH-1:0]             table_q [TABLE_SIZE];
    logic [DATA_WIDTH-1:0]             table_d [TABLE_SIZE];
    logic [OUTPUT_RATE*DATA_WIDTH-1:0] rd_q;
    logic [OUTPUT_RATE*DATA_WIDTH-1:0] rd_d;
    logic [INPUT_RATE-1:0]             wr_ok;
    logic [OUTPUT_RATE-1:0]            rd_ok;

    // Every index is legal when the table fills the whole index space.
    generate
        if (POW2) begin : g_full
            assign wr_ok = '1;
            assign rd_ok = '1;
        end else begin : g_partial
            for (genvar i = 0; i < INPUT_RATE; i++) begin : g_wr
                assign wr_ok[i] = {1'b0, index_wr[i*IW +: IW]} < (IW+1)'(TABLE_SIZE);
            end
            for (genvar j = 0; j < OUTPUT_RATE; j++) begin : g_rd
                assign rd_ok[j] = {1'b0, index_rd[j*IW +: IW]} < (IW+1)'(TABLE_SIZE);
            end
        end
    endgenerate

    always_comb begin
        // NOTE: start from the held value so no path leaves table_d unassigned (no latch).
        table_d = table_q;
        // Ascending lane order lets the highest enabled lane win a collision.
        for (int i = 0; i < INPUT_RATE; i++) begin
            if (wr_en[i] && wr_ok[i]) begin
                table_d[index_wr[i*IW +: IW]] = data_wr[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            for (int j = 0; j < OUTPUT_RATE; j++) begin
                rd_d[j*DATA_WIDTH +: DATA_WIDTH] =
                    rd_ok[j] ? table_q[index_rd[j*IW +: IW]] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table is plain flops, not a RAM macro, so clearing it on reset is legal.
            for (int k = 0; k < TABLE_SIZE; k++) begin
                table_q[k] <= '0;
            end
            rd_q <= '0;
        end else begin
            table_q <= table_d;
            rd_q    <= rd_d;
        end
    end

    assign data_rd = rd_q;

endmodule

// File: tb/tb_modport_table.sv
// Directed bench for modport_table: reset, dual write, collision, read-during-write,
// read hold, and asynchronous reset mid-traffic.
module tb_modport_table;

    logic        clk;
    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  index_wr;
    logic [15:0] data_wr;
    logic        rd_en;
    logic [9:0]  index_rd;
    logic [15:0] data_rd;

    int vectors;
    int miscompares;

    modport_table dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .index_wr (index_wr),
        .data_wr  (data_wr),
        .rd_en    (rd_en),
        .index_rd (index_rd),
        .data_rd  (data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        wr_en    = 2'b11;
        index_wr = {5'd31, 5'd0};
        data_wr  = 16'hFFFF;
        rd_en    = 1'b1;
        index_rd = {5'd31, 5'd0};
        tick();
        tick();
        vectors++;
        if (data_rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held data_rd=%h expected=%h", data_rd, 16'h0000);
        end
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 2'b00;
        tick();
        vectors++;
        if (data_rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_read_0_31 data_rd=%h expected=%h", data_rd, 16'h0000);
        end
    endtask

    task automatic test_dual_write();
        wr_en    = 2'b11;
        index_wr = {5'd7, 5'd3};
        data_wr  = {8'hB7, 8'hA3};
        rd_en    = 1'b0;
        tick();
        wr_en    = 2'b00;
        rd_en    = 1'b1;
        index_rd = {5'd3, 5'd7};
        tick();
        vectors++;
        if (data_rd !== 16'hA3B7) begin
            miscompares++;
            $display("FAIL dual_write data_rd=%h expected=%h", data_rd, 16'hA3B7);
        end
        index_rd = {5'd7, 5'd3};
        tick();
        vectors++;
        if (data_rd !== 16'hB7A3) begin
            miscompares++;
            $display("FAIL dual_write_swap data_rd=%h expected=%h", data_rd, 16'hB7A3);
        end
    endtask

    task automatic test_collision();
        wr_en    = 2'b11;
        index_wr = {5'd10, 5'd10};
        data_wr  = {8'h22, 8'h11};
        rd_en    = 1'b0;
        tick();
        wr_en    = 2'b00;
        rd_en    = 1'b1;
        index_rd = {5'd10, 5'd10};
        tick();
        vectors++;
        if (data_rd !== 16'h2222) begin
            miscompares++;
            $display("FAIL collision data_rd=%h expected=%h", data_rd, 16'h2222);
        end
    endtask

    task automatic test_read_during_write();
        wr_en    = 2'b01;
        index_wr = {5'd0, 5'd5};
        data_wr  = {8'h00, 8'h55};
        rd_en    = 1'b0;
        tick();
        data_wr  = {8'h00, 8'hAA};
        rd_en    = 1'b1;
        index_rd = {5'd5, 5'd5};
        tick();
        vectors++;
        if (data_rd !== 16'h5555) begin
            miscompares++;
            $display("FAIL rdw_old data_rd=%h expected=%h", data_rd, 16'h5555);
        end
        wr_en = 2'b00;
        tick();
        vectors++;
        if (data_rd !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL rdw_new data_rd=%h expected=%h", data_rd, 16'hAAAA);
        end
    endtask

    task automatic test_read_hold();
        logic [9:0] idx_seq [3];
        idx_seq[0] = {5'd3, 5'd5};
        idx_seq[1] = {5'd7, 5'd10};
        idx_seq[2] = {5'd31, 5'd1};
        // Lane 1 carries index 9 / data EE but is disabled.
        wr_en    = 2'b01;
        index_wr = {5'd9, 5'd0};
        data_wr  = {8'hEE, 8'h3C};
        rd_en    = 1'b0;
        tick();
        wr_en    = 2'b00;
        rd_en    = 1'b1;
        index_rd = {5'd9, 5'd0};
        tick();
        vectors++;
        if (data_rd !== 16'h003C) begin
            miscompares++;
            $display("FAIL single_lane_write data_rd=%h expected=%h", data_rd, 16'h003C);
        end
        rd_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            index_rd = idx_seq[c];
            tick();
            vectors++;
            if (data_rd !== 16'h003C) begin
                miscompares++;
                $display("FAIL read_hold cycle=%0d data_rd=%h expected=%h", c, data_rd, 16'h003C);
            end
        end
    endtask

    task automatic test_async_reset();
        rd_en = 1'b0;
        wr_en = 2'b11;
        for (int i = 0; i < 16; i++) begin
            index_wr = {5'(i + 16), 5'(i)};
            data_wr  = {8'(i + 17), 8'(i + 1)};
            tick();
        end
        wr_en    = 2'b00;
        rd_en    = 1'b1;
        index_rd = {5'd31, 5'd0};
        tick();
        vectors++;
        if (data_rd !== 16'h2001) begin
            miscompares++;
            $display("FAIL fill_check data_rd=%h expected=%h", data_rd, 16'h2001);
        end
        // Leave a write in flight while reset pulses between edges.
        wr_en    = 2'b11;
        index_wr = {5'd20, 5'd4};
        data_wr  = 16'h7777;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (data_rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_clear data_rd=%h expected=%h", data_rd, 16'h0000);
        end
        #1 rst = 1'b0;
        wr_en = 2'b00;
        for (int i = 0; i < 16; i++) begin
            index_rd = {5'(31 - i), 5'(i)};
            tick();
            vectors++;
            if (data_rd !== 16'h0000) begin
                miscompares++;
                $display("FAIL post_reset_read idx=%0d/%0d data_rd=%h expected=%h",
                         i, 31 - i, data_rd, 16'h0000);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_en    = 2'b11;
        index_wr = {5'd12, 5'd11};
        data_wr  = {8'hC2, 8'hC1};
        rd_en    = 1'b0;
        tick();
        index_wr = {5'd14, 5'd13};
        data_wr  = {8'hD4, 8'hD3};
        rd_en    = 1'b1;
        index_rd = {5'd12, 5'd11};
        tick();
        vectors++;
        if (data_rd !== 16'hC2C1) begin
            miscompares++;
            $display("FAIL b2b_first data_rd=%h expected=%h", data_rd, 16'hC2C1);
        end
        wr_en    = 2'b00;
        index_rd = {5'd13, 5'd14};
        tick();
        vectors++;
        if (data_rd !== 16'hD3D4) begin
            miscompares++;
            $display("FAIL b2b_second data_rd=%h expected=%h", data_rd, 16'hD3D4);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_dual_write();
        test_collision();
        test_read_during_write();
        test_read_hold();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
